// File: rtl/dpcm_multi_if.sv
// Sample/result bus for dpcm_multi: upstream (mode, in_data) handshake plus the
// registered DPCM output handshake. "slave" is the DPCM block side.
interface dpcm_multi_if #(
    parameter int DATA_W = 12
);
    logic [1:0]               mode;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W:0]   out_data;
    logic [1:0]               out_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_first;
    logic                     out_last;

    modport slave (
        input  mode, in_data, in_valid, out_ready,
        output in_ready, out_data, out_mode, out_valid, out_first, out_last
    );

    modport master (
        output mode, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_mode, out_valid, out_first, out_last
    );
endinterface

// File: rtl/dpcm_multi.sv
// Three-channel (Y/Cr/Cb) DC-coefficient DPCM encoder with per-channel predictor
// and frame counter; one registered output stage with valid/ready flow control.
module dpcm_multi #(
    parameter int DATA_W  = 12,
    parameter int BLK_NUM = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    dpcm_multi_if.slave  bus
);
    localparam int CNT_W = $clog2(BLK_NUM + 1);

    typedef enum logic [1:0] {
        CH_NONE = 2'b00,
        CH_Y    = 2'b01,
        CH_CR   = 2'b10,
        CH_CB   = 2'b11
    } chan_e;

    logic signed [DATA_W-1:0] prev_q [3];
    logic signed [DATA_W-1:0] prev_d [3];
    logic [CNT_W-1:0]         cnt_q  [3];
    logic [CNT_W-1:0]         cnt_d  [3];

    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W:0]   out_data_q,  out_data_d;
    logic [1:0]               out_mode_q,  out_mode_d;
    logic                     out_first_q, out_first_d;
    logic                     out_last_q,  out_last_d;

    chan_e                    chan;
    logic [1:0]               idx;
    logic                     accept;
    logic                     take;
    logic                     is_last;
    logic signed [DATA_W:0]   diff;

    assign chan          = chan_e'(bus.mode);
    assign bus.in_ready  = rst && (!out_valid_q || bus.out_ready) && !clear;
    assign accept        = bus.in_valid && bus.in_ready;
    assign take          = accept && (chan != CH_NONE);

    always_comb begin
        idx = 2'd0;
        case (chan)
            CH_Y:    idx = 2'd0;
            CH_CR:   idx = 2'd1;
            CH_CB:   idx = 2'd2;
            default: idx = 2'd0;
        endcase
    end

    // Both operands widened by one bit so the difference never wraps.
    assign diff    = {bus.in_data[DATA_W-1], bus.in_data}
                   - {prev_q[idx][DATA_W-1], prev_q[idx]};
    assign is_last = (cnt_q[idx] == CNT_W'(BLK_NUM - 1));

    always_comb begin
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mode_d  = out_mode_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;

        if (clear) begin
            for (int unsigned i = 0; i < 3; i++) begin
                prev_d[i] = '0;
                cnt_d[i]  = '0;
            end
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_mode_d  = '0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (take) begin
            out_valid_d = 1'b1;
            out_mode_d  = bus.mode;
            out_first_d = (cnt_q[idx] == '0);
            out_last_d  = is_last;
            out_data_d  = (cnt_q[idx] == '0) ? {bus.in_data[DATA_W-1], bus.in_data} : diff;
            if (is_last) begin
                prev_d[idx] = '0;
                cnt_d[idx]  = '0;
            end else begin
                prev_d[idx] = bus.in_data;
                cnt_d[idx]  = cnt_q[idx] + CNT_W'(1);
            end
        end else if (out_valid_q && bus.out_ready) begin
            // Emptied without refill (includes a dropped mode=00 sample).
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_mode_d  = '0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                prev_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mode_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mode_q  <= out_mode_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_mode  = out_mode_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
endmodule
